mc_controller: RTL
==================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous, active-low reset (0 = reset).
REQ-004 op  in  6  opcode of the instruction register.
REQ-005 funct  in  6  function field of the instruction register.
REQ-006 zero  in  1  ALU zero flag.
REQ-007 memready  in  1  memory completes the current request this cycle.
REQ-008 memreq  out  1  memory request is active.
REQ-009 iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-010 memwrite  out  1  memory write strobe.
REQ-011 irwrite  out  1  instruction register load.
REQ-012 regwrite  out  1  register file write.
REQ-013 regdst  out  1  write register select: 0 = rt, 1 = rd.
REQ-014 memtoreg  out  1  writeback select: 0 = ALUOut, 1 = memory data.
REQ-015 alusrca  out  1  ALU A select: 0 = PC, 1 = register A.
REQ-016 alusrcb  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = shifted immediate.
REQ-017 pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-018 pcen  out  1  PC register enable.
REQ-019 alucontrol  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-020 illegal  out  1  one-cycle pulse on an unsupported opcode.

Function
REQ-021 Supported opcodes SHALL be R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000 and j 000010.
REQ-022 The FSM states SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB and JUMP.
REQ-023 FETCH: memreq=1, iord=0, alusrca=0, alusrcb=01, aluop=add, pcsrc=00; irwrite and pcwrite SHALL equal memready; the state SHALL hold until memready=1, then go to DECODE.
REQ-024 DECODE: alusrca=0, alusrcb=11, aluop=add (branch-target precompute).
  - lw/sw -> MEMADR; R-type -> EXECUTE; beq/bne -> BRANCH; addi -> ADDIEX; j -> JUMP.
  - Any other opcode -> FETCH, with illegal=1 for that cycle.
REQ-025 MEMADR: alusrca=1, alusrcb=10, aluop=add; lw -> MEMRD, sw -> MEMWR.
REQ-026 MEMRD: memreq=1, iord=1; the state SHALL hold until memready=1, then go to MEMWB.
REQ-027 MEMWB: regwrite=1, regdst=0, memtoreg=1; next state FETCH.
REQ-028 MEMWR: memreq=1, memwrite=1, iord=1; both SHALL stay asserted until memready=1, then next state FETCH.
REQ-029 EXECUTE: alusrca=1, alusrcb=00, aluop=funct -> ALUWB.
  - ALUWB: regwrite=1, regdst=1, memtoreg=0 -> FETCH.
REQ-030 BRANCH: alusrca=1, alusrcb=00, aluop=sub, pcsrc=01 -> FETCH.
  - beq: pcen=zero; bne: pcen=~zero.
REQ-031 ADDIEX: alusrca=1, alusrcb=10, aluop=add -> ADDIWB.
  - ADDIWB: regwrite=1, regdst=0, memtoreg=0 -> FETCH.
REQ-032 JUMP: pcsrc=10, pcwrite=1 -> FETCH.
REQ-033 pcen SHALL equal pcwrite | (beq-branch & zero) | (bne-branch & ~zero).
REQ-034 All outputs SHALL be combinational from the state, op and memready (Moore plus memready gating); every output not listed for a state SHALL be 0.
REQ-035 aluop SHALL map to alucontrol: add -> 010, sub -> 110, funct -> the funct decode (100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, otherwise 010).
REQ-036 Instruction latencies from FETCH (with memready=1) SHALL be: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3 cycles.

Reset
REQ-037 reset=0 SHALL asynchronously force the state to FETCH.
REQ-038 While reset=0, pcen, irwrite, regwrite, memwrite, memreq and illegal SHALL be 0, and the other outputs SHALL take their FETCH values.
REQ-039 Reset asserted mid-instruction (including a held MEMWR) SHALL abort that instruction with no further write strobes; the first cycle after release SHALL be FETCH.

Structure
REQ-040 A shared package SHALL hold the state enum, the opcode and funct constants, the aluop encoding (00 add, 01 sub, 10 funct) and the alucontrol constants.
REQ-041 The existing ALU decoder module aludec SHALL be instantiated as the one sub-module for the aluop/funct -> alucontrol mapping.

Verification
REQ-042 lw (op=100011), memready=1 throughout -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 with memtoreg=1 only in cycle 5.
REQ-043 sw with memready low for 3 MEMWR cycles -> memwrite=1 for 4 cycles, then FETCH; regwrite=0 throughout.
REQ-044 beq, zero=1 -> pcen=1 in BRANCH; bne, zero=1 -> pcen=0; pcsrc=01 in both cases.
REQ-045 R-type with funct=101010 -> alucontrol=111 in EXECUTE; ALUWB shows regwrite=1, regdst=1.
REQ-046 op=111111 -> illegal=1 for one cycle in DECODE, next state FETCH, no write strobes.
REQ-047 reset driven low during MEMRD -> state FETCH immediately (asynchronously); memreq=0 while reset is low; normal fetch after release.

Source files
------------

// File: rtl/mc_controller_pkg.sv
// Shared types and constants for the multicycle controller.
// Holds the FSM state enum, opcode/funct fields and ALU encodings.
package mc_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECUTE,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_controller_aludec.sv
// ALU decoder: maps aluop and funct to the ALU control code.
// Unknown funct values fall back to add.
module aludec
  import mc_controller_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS-style main controller.
// Moore outputs from state and op, gated by memready and reset.
module mc_controller
  import mc_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       memreq,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  state_t state_q, state_d;
  aluop_t aluop;
  logic   pcwrite;
  logic   beq_br;
  logic   bne_br;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (memready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_RTYPE:       state_d = S_EXECUTE;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:        state_d = S_ADDIEX;
          OP_J:           state_d = S_JUMP;
          default:        state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (memready) state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   if (memready) state_d = S_FETCH;
      S_EXECUTE: state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    memreq   = 1'b0;
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = ALUOP_ADD;
    pcwrite  = 1'b0;
    beq_br   = 1'b0;
    bne_br   = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        memreq  = 1'b1;
        alusrcb = 2'b01;
        irwrite = memready;
        pcwrite = memready;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ,
          OP_BNE, OP_ADDI, OP_J: illegal = 1'b0;
          default:               illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        memreq = 1'b1;
        iord   = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        memreq   = 1'b1;
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        beq_br  = (op == OP_BEQ);
        bne_br  = (op == OP_BNE);
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
    // state is already FETCH under reset; only the strobes need gating
    if (!reset) begin
      memreq   = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      memwrite = 1'b0;
      pcwrite  = 1'b0;
      beq_br   = 1'b0;
      bne_br   = 1'b0;
      illegal  = 1'b0;
    end
  end

  assign pcen = pcwrite | (beq_br & zero) | (bne_br & ~zero);

  aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule
